// File: rtl/matmul_pkg.sv
// Shared constants, sequencer state encoding and the row-major address helper
// used by the operand/result RAMs, the loader and the multiply sequencer.
package matmul_pkg;

    localparam int N    = 8;
    localparam int DW   = 8;
    localparam int AW   = 6;
    localparam int ACCW = 19;
    localparam int IW   = $clog2(N);
    localparam int KPW  = $clog2(N / 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    function automatic logic [AW-1:0] idx(input logic [IW-1:0] row, input logic [IW-1:0] col);
        return AW'(int'(row) * N + int'(col));
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_mac_pair.sv
// Two-lane signed multiply-accumulate: forms a1*b1 + a2*b2 each cycle and
// loads, accumulates or emits the running dot product.
module mac_pair
    import matmul_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_vld,
    input  logic                   i_load,
    input  logic                   i_emit,
    input  logic signed [DW-1:0]   i_a1,
    input  logic signed [DW-1:0]   i_a2,
    input  logic signed [DW-1:0]   i_b1,
    input  logic signed [DW-1:0]   i_b2,
    output logic signed [ACCW-1:0] o_res,
    output logic                   o_wr
);

    logic signed [2*DW-1:0] w_p1, w_p2;
    logic signed [ACCW-1:0] w_pair;
    logic signed [ACCW-1:0] r_acc, r_res;
    logic                   r_wr;

    function automatic logic signed [ACCW-1:0] sext_prod(input logic signed [2*DW-1:0] p);
        return {{(ACCW - 2*DW){p[2*DW-1]}}, p};
    endfunction

    assign w_p1   = i_a1 * i_b1;
    assign w_p2   = i_a2 * i_b2;
    assign w_pair = sext_prod(w_p1) + sext_prod(w_p2);

    // Accumulate stage: the emitted sum includes the final pair directly
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_res <= '0;
            r_wr  <= 1'b0;
        end else begin
            r_wr <= i_vld & i_emit;
            if (i_vld) begin
                r_acc <= i_load ? w_pair : r_acc + w_pair;
                if (i_emit) begin
                    r_res <= r_acc + w_pair;
                end
            end
        end
    end

    assign o_res = r_res;
    assign o_wr  = r_wr;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// 8x8 signed matrix-multiply sequencer: walks i/j/kp, issues paired A/B reads,
// and writes each finished C element through a two-lane MAC.
module matmul_seq_ctrl
    import matmul_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [AW-1:0]          addr_a1,
    output logic [AW-1:0]          addr_a2,
    output logic [AW-1:0]          addr_b1,
    output logic [AW-1:0]          addr_b2,
    input  logic signed [DW-1:0]   data_a1,
    input  logic signed [DW-1:0]   data_a2,
    input  logic signed [DW-1:0]   data_b1,
    input  logic signed [DW-1:0]   data_b2,
    output logic [AW-1:0]          c_addr,
    output logic signed [ACCW-1:0] c_data,
    output logic                   c_wr
);

    state_t          r_state, w_state_nxt;
    logic            r_done, w_done_nxt;
    logic [IW-1:0]   r_i, r_j;
    logic [KPW-1:0]  r_kp;
    logic            w_issue, w_last_issue;
    logic [IW-1:0]   w_k0, w_k1;
    logic            r_vld_p1, r_last_p1, r_last_p2;
    logic [KPW-1:0]  r_kp_p1;
    logic [AW-1:0]   r_cidx_p1, r_c_addr;
    logic            w_wr;
    logic signed [ACCW-1:0] w_res;

    assign w_issue      = (r_state == RUN);
    assign w_last_issue = w_issue && (r_i == IW'(N-1)) && (r_j == IW'(N-1))
                          && (r_kp == KPW'(N/2-1));
    assign w_k0         = {r_kp, 1'b0};
    assign w_k1         = {r_kp, 1'b1};

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last_issue) w_state_nxt = DRAIN;
            DRAIN: begin
                if (w_wr && r_last_p2) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Issue stage: counters wrap naturally back to zero after the last pair
    always_ff @(posedge clk) begin
        if (reset || (r_state == IDLE && start)) begin
            r_i  <= '0;
            r_j  <= '0;
            r_kp <= '0;
        end else if (w_issue) begin
            r_kp <= r_kp + 1'b1;
            if (r_kp == KPW'(N/2-1)) begin
                r_j <= r_j + 1'b1;
                if (r_j == IW'(N-1)) begin
                    r_i <= r_i + 1'b1;
                end
            end
        end
    end

    // Data-return stage: tags line up with the RAM's registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_kp_p1   <= '0;
            r_cidx_p1 <= '0;
        end else begin
            r_vld_p1  <= w_issue;
            r_last_p1 <= w_last_issue;
            r_kp_p1   <= r_kp;
            r_cidx_p1 <= idx(r_i, r_j);
        end
    end

    // Write stage: address and last-tag travel with the MAC result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_addr  <= '0;
            r_last_p2 <= 1'b0;
        end else begin
            r_last_p2 <= r_vld_p1 & r_last_p1;
            if (r_vld_p1 && r_kp_p1 == KPW'(N/2-1)) begin
                r_c_addr <= r_cidx_p1;
            end
        end
    end

    mac_pair u_mac (
        .clk    (clk),
        .reset  (reset),
        .i_vld  (r_vld_p1),
        .i_load (r_kp_p1 == '0),
        .i_emit (r_kp_p1 == KPW'(N/2-1)),
        .i_a1   (data_a1),
        .i_a2   (data_a2),
        .i_b1   (data_b1),
        .i_b2   (data_b2),
        .o_res  (w_res),
        .o_wr   (w_wr)
    );

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign addr_a1 = w_issue ? idx(r_i, w_k0) : '0;
    assign addr_a2 = w_issue ? idx(r_i, w_k1) : '0;
    assign addr_b1 = w_issue ? idx(w_k0, r_j) : '0;
    assign addr_b2 = w_issue ? idx(w_k1, r_j) : '0;
    assign c_addr  = r_c_addr;
    assign c_data  = w_res;
    assign c_wr    = w_wr & ~reset;

endmodule
